// File: rtl/mem_responder.sv
// Wait-stated, handshaked word memory responder for the CPU data port.
// One request in flight: accept in IDLE, count wait states, access, one-cycle ack.
module mem_responder #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [3:0]  be,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ack,
  output logic        err,
  output logic        busy,
  output logic [7:0]  err_count
);

  localparam int         DEPTH    = 1 << ADDR_WIDTH;
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } mem_req_t;

  state_t                state, state_nxt;
  logic [3:0]            wait_cnt;
  mem_req_t              cap_req, live_req, acc_req;
  logic                  accept, do_access, acc_err, mem_wr;
  logic [ADDR_WIDTH-1:0] acc_idx;
  logic [31:0]           mem [DEPTH];

  assign live_req = '{we: we, addr: addr, be: be, wdata: wdata};
  assign accept   = (state == S_IDLE) && req;
  assign busy     = (state != S_IDLE);

  // With no wait states the access happens on the accept edge itself,
  // so it must use the request as presented rather than the captured copy.
  assign acc_req = (WAIT_CYCLES == 0) ? live_req : cap_req;
  assign acc_idx = acc_req.addr[ADDR_WIDTH+1:2];
  assign acc_err = (acc_req.addr[1:0] != 2'b00) ||
                   ((acc_req.addr >> (ADDR_WIDTH + 2)) != 32'd0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    do_access = 1'b0;
    case (state)
      S_IDLE: begin
        if (req) begin
          if (WAIT_CYCLES == 0) begin
            do_access = 1'b1;
            state_nxt = S_RESP;
          end else begin
            state_nxt = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (wait_cnt == 4'd0) begin
          do_access = 1'b1;
          state_nxt = S_RESP;
        end
      end
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // reset_n gate keeps a reset that lands on an access edge from committing the write
  assign mem_wr = do_access && acc_req.we && !acc_err && reset_n;

  always_ff @(posedge clk) begin
    if (mem_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (acc_req.be[i]) mem[acc_idx][8*i +: 8] <= acc_req.wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cap_req   <= '0;
      wait_cnt  <= 4'd0;
      ack       <= 1'b0;
      err       <= 1'b0;
      rdata     <= 32'd0;
      err_count <= 8'd0;
    end else begin
      if (accept) begin
        cap_req  <= live_req;
        wait_cnt <= CNT_INIT;
      end else if ((state == S_WAIT) && (wait_cnt != 4'd0)) begin
        wait_cnt <= wait_cnt - 4'd1;
      end

      if (do_access) begin
        ack <= 1'b1;
        if (acc_err) begin
          err   <= 1'b1;
          rdata <= 32'd0;
          if (err_count != 8'hFF) err_count <= err_count + 8'd1;
        end else begin
          err   <= 1'b0;
          rdata <= acc_req.we ? 32'd0 : mem[acc_idx];
        end
      end else if (state == S_RESP) begin
        ack <= 1'b0;
        err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: three instances cover 1, 3 and 0 wait states.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  req_v = 3'b000;
  logic        we = 1'b0;
  logic [31:0] addr = 32'd0;
  logic [3:0]  be = 4'd0;
  logic [31:0] wdata = 32'd0;

  logic [31:0] rdata_v [3];
  logic [2:0]  ack_v, err_v, busy_v;
  logic [7:0]  ec_v [3];

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(1)) u_dut_w1 (
    .clk(clk), .reset_n(reset_n), .req(req_v[0]), .we(we), .addr(addr), .be(be),
    .wdata(wdata), .rdata(rdata_v[0]), .ack(ack_v[0]), .err(err_v[0]),
    .busy(busy_v[0]), .err_count(ec_v[0]));

  mem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(3)) u_dut_w3 (
    .clk(clk), .reset_n(reset_n), .req(req_v[1]), .we(we), .addr(addr), .be(be),
    .wdata(wdata), .rdata(rdata_v[1]), .ack(ack_v[1]), .err(err_v[1]),
    .busy(busy_v[1]), .err_count(ec_v[1]));

  mem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(0)) u_dut_w0 (
    .clk(clk), .reset_n(reset_n), .req(req_v[2]), .we(we), .addr(addr), .be(be),
    .wdata(wdata), .rdata(rdata_v[2]), .ack(ack_v[2]), .err(err_v[2]),
    .busy(busy_v[2]), .err_count(ec_v[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One transaction on instance s; inputs are scrambled right after accept
  // so any late sampling of them shows up as wrong data.
  task automatic xact(input int s, input logic w, input logic [31:0] a, input logic [3:0] b,
                      input logic [31:0] d, output logic [31:0] rd, output logic e,
                      output int lat, output int bcnt);
    @(negedge clk);
    we = w; addr = a; be = b; wdata = d; req_v[s] = 1'b1;
    @(posedge clk);
    #1;
    req_v[s] = 1'b0; we = ~w; addr = 32'hFFFF_FFFF; be = ~b; wdata = ~d;
    lat = 0; bcnt = 0; rd = 32'd0; e = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (busy_v[s]) bcnt++;
      if (ack_v[s]) begin
        lat = k; rd = rdata_v[s]; e = err_v[s];
        break;
      end
    end
    if (lat == 0) chk("ack_timeout", 32'd0, 32'd1);
    else begin
      @(negedge clk);
      if (busy_v[s]) bcnt++;
      chk("ack_one_cycle", {31'd0, ack_v[s]}, 32'd0);
    end
  endtask

  task automatic wr(input int s, input logic [31:0] a, input logic [3:0] b,
                    input logic [31:0] d, input logic exp_err, input string tag);
    logic [31:0] rd; logic e; int lat, bc;
    xact(s, 1'b1, a, b, d, rd, e, lat, bc);
    chk({tag, "_err"}, {31'd0, e}, {31'd0, exp_err});
  endtask

  task automatic rd_chk(input int s, input logic [31:0] a, input logic [31:0] exp,
                        input logic exp_err, input string tag);
    logic [31:0] rd; logic e; int lat, bc;
    xact(s, 1'b0, a, 4'hF, 32'd0, rd, e, lat, bc);
    chk({tag, "_err"}, {31'd0, e}, {31'd0, exp_err});
    chk({tag, "_data"}, rd, exp);
  endtask

  initial begin
    logic [31:0] rd; logic e; int lat, bc, acks;

    // reset state
    #12;
    chk("rst_rdata", rdata_v[0], 32'd0);
    chk("rst_ack", {31'd0, ack_v[0]}, 32'd0);
    chk("rst_err", {31'd0, err_v[0]}, 32'd0);
    chk("rst_busy", {29'd0, busy_v}, 32'd0);
    chk("rst_errcnt", {24'd0, ec_v[0]}, 32'd0);
    @(negedge clk); reset_n = 1'b1;
    acks = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (ack_v != 3'b000) acks++;
    end
    chk("idle_no_ack", 32'(acks), 32'd0);

    // write/read with one wait state, plus latency and busy window
    xact(0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, rd, e, lat, bc);
    chk("wr10_err", {31'd0, e}, 32'd0);
    chk("wr10_lat", 32'(lat), 32'd2);
    chk("wr10_busy", 32'(bc), 32'd2);
    chk("wr10_rdata0", rd, 32'd0);
    rd_chk(0, 32'h10, 32'hDEADBEEF, 1'b0, "rd10");

    // byte enables
    wr(0, 32'h20, 4'b1111, 32'h11223344, 1'b0, "wr20_full");
    wr(0, 32'h20, 4'b0101, 32'hAABBCCDD, 1'b0, "wr20_be5");
    rd_chk(0, 32'h20, 32'h11BB33DD, 1'b0, "rd20");
    wr(0, 32'h10, 4'b0000, 32'h0, 1'b0, "wr10_be0");
    rd_chk(0, 32'h10, 32'hDEADBEEF, 1'b0, "rd10_after_be0");

    // errors: misaligned read, out-of-range write must not alias word 0
    rd_chk(0, 32'h22, 32'd0, 1'b1, "rd22_misalign");
    chk("errcnt_1", {24'd0, ec_v[0]}, 32'd1);
    wr(0, 32'h0, 4'hF, 32'hCAFEF00D, 1'b0, "wr0");
    wr(0, 32'h1000, 4'hF, 32'h55555555, 1'b1, "wr1000_oor");
    chk("errcnt_2", {24'd0, ec_v[0]}, 32'd2);
    rd_chk(0, 32'h0, 32'hCAFEF00D, 1'b0, "rd0_unchanged");

    // reset during WAIT discards the write and suppresses ack
    wr(0, 32'h30, 4'hF, 32'h0, 1'b0, "wr30_zero");
    @(negedge clk);
    we = 1'b1; addr = 32'h30; be = 4'hF; wdata = 32'h12345678; req_v[0] = 1'b1;
    @(posedge clk); #1; req_v[0] = 1'b0;
    @(negedge clk);
    chk("midop_in_wait", {31'd0, busy_v[0]}, 32'd1);
    reset_n = 1'b0;
    #1;
    chk("midop_busy_clr", {31'd0, busy_v[0]}, 32'd0);
    acks = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (ack_v[0]) acks++;
    end
    reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (ack_v[0]) acks++;
    end
    chk("midop_no_ack", 32'(acks), 32'd0);
    chk("midop_errcnt_clr", {24'd0, ec_v[0]}, 32'd0);
    rd_chk(0, 32'h30, 32'h0, 1'b0, "rd30_after_rst");

    // error counter saturation
    for (int k = 0; k < 254; k++) xact(0, 1'b0, 32'h22, 4'hF, 32'd0, rd, e, lat, bc);
    chk("errcnt_254", {24'd0, ec_v[0]}, 32'd254);
    for (int k = 0; k < 46; k++) xact(0, 1'b0, 32'h22, 4'hF, 32'd0, rd, e, lat, bc);
    chk("errcnt_sat", {24'd0, ec_v[0]}, 32'd255);

    // three wait states, req held high: ack at negedges 4, 9, 14, ...
    @(negedge clk);
    we = 1'b0; addr = 32'h0; be = 4'hF; req_v[1] = 1'b1;
    acks = 0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (ack_v[1]) acks++;
      if (k % 5 == 4) chk("w3_ack_slot", {31'd0, ack_v[1]}, 32'd1);
      else            chk("w3_no_ack", {31'd0, ack_v[1]}, 32'd0);
    end
    req_v[1] = 1'b0;
    chk("w3_ack_total", 32'(acks), 32'd6);
    xact(1, 1'b1, 32'h8, 4'hF, 32'h600DF00D, rd, e, lat, bc);
    chk("w3_lat", 32'(lat), 32'd4);
    chk("w3_busy", 32'(bc), 32'd4);
    rd_chk(1, 32'h8, 32'h600DF00D, 1'b0, "w3_rd8");

    // zero wait states
    xact(2, 1'b1, 32'h40, 4'hF, 32'h0BADCAFE, rd, e, lat, bc);
    chk("w0_lat", 32'(lat), 32'd1);
    chk("w0_busy", 32'(bc), 32'd1);
    rd_chk(2, 32'h40, 32'h0BADCAFE, 1'b0, "w0_rd40");
    rd_chk(2, 32'h41, 32'h0, 1'b1, "w0_misalign");

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
Memory-side responder for the CPU's data-memory request interface. It accepts one word read or write request at a time, inserts a programmable number of wait states, and performs the access on an internal word array with byte enables. It returns a one-cycle ack with read data or an error flag. It is the target the multi-cycle CPU core drives in its MEM state, and it replaces the bare RAM with a handshaked, wait-stated slave.

Parameters:
ADDR_WIDTH, 10, word-address bits; array depth = 2^ADDR_WIDTH words of 32 bits.
WAIT_CYCLES, 1, wait states inserted between accept and access (0..15).

Ports:
clk  input  1  clock; all state changes on the rising edge.
reset_n  input  1  asynchronous active-low reset.
req  input  1  request strobe; sampled only in IDLE.
we  input  1  1 = write, 0 = read; captured with req.
addr  input  32  byte address; captured with req.
be  input  4  byte enables, be[i] selects wdata[8i+7:8i]; captured with req.
wdata  input  32  write data; captured with req.
rdata  output  32  read data; valid while ack=1.
ack  output  1  response strobe, high for exactly one cycle per accepted request.
err  output  1  error response, qualified by ack.
busy  output  1  high whenever state != IDLE.
err_count  output  8  saturating count of error responses.

Behaviour:
- Reset (asynchronous, reset_n=0): state=IDLE, ack=0, err=0, rdata=0, err_count=0, wait counter=0, captured request cleared. The memory array is not reset; simulation init is all zeros.
- Reset mid-operation aborts the request. A pending write is discarded and no ack is issued.
- States: IDLE, WAIT, RESP.
- IDLE:
  - If req=1 at edge E0, capture we/addr/be/wdata.
  - If WAIT_CYCLES>0: go to WAIT, counter=WAIT_CYCLES-1.
  - If WAIT_CYCLES=0: do the access at E0 and go to RESP.
- WAIT:
  - If counter!=0, decrement.
  - If counter==0, do the access on this edge and go to RESP.
- Access edge:
  - Set ack<=1.
  - Valid write: for each i with be[i]=1, update byte i of mem[addr[ADDR_WIDTH+1:2]]; other bytes are unchanged. Set rdata<=0 and err<=0.
  - Valid read: set rdata<=full word (be is ignored) and err<=0.
  - Error: no array update, rdata<=0, err<=1, err_count increments, saturating at 255.
- RESP: ack=1 for this single cycle. At the next edge: ack<=0, err<=0, go to IDLE. rdata holds its value until the next access edge.
- Latency: ack is visible in the cycle after edge E0+WAIT_CYCLES, i.e. WAIT_CYCLES+1 cycles after req was sampled.
- Error conditions, evaluated on the captured address:
  - misaligned: addr[1:0] != 0;
  - out of range: addr[31:ADDR_WIDTH+2] != 0.
- req while busy (WAIT or RESP) is ignored and never queued. The initiator re-asserts req after ack. Minimum spacing between accepts is WAIT_CYCLES+2 edges.
- A write with be=0000 is a valid no-op write: ack=1, err=0.
- Read-after-write to the same word returns the updated data. There is no forwarding hazard, since only one request is ever outstanding.
- Captured inputs are used for the whole transaction. Changes on we/addr/be/wdata after the accept edge have no effect.

Test Plan:
- Reset then idle: reset_n=0 -> rdata=0, ack=0, err=0, busy=0, err_count=0. req=0 for 10 cycles -> ack stays 0.
- Write/read, WAIT_CYCLES=1:
  - Write addr=0x10, wdata=0xDEADBEEF, be=1111 -> ack high exactly 2 cycles after the req sample, err=0, busy high for 2 cycles.
  - Read addr=0x10 -> rdata=0xDEADBEEF with ack.
- Byte enables:
  - Write 0x11223344 to addr=0x20 with be=1111.
  - Write 0xAABBCCDD to addr=0x20 with be=0101.
  - Read addr=0x20 -> 0x11BB33DD.
- Errors:
  - Read addr=0x22 (misaligned) -> ack=1, err=1, rdata=0.
  - Write addr=0x00001000 with ADDR_WIDTH=10 (out of range) -> err=1, and a read of addr=0x0 is unchanged.
  - 300 error requests -> err_count=255.
- Busy and zero-wait:
  - With WAIT_CYCLES=3, hold req=1 continuously -> one ack per 5 cycles, none dropped or duplicated.
  - With WAIT_CYCLES=0 -> ack in the cycle after the accept edge.
- Reset mid-op:
  - Write 0x12345678 to addr=0x30, assert reset_n=0 during WAIT -> no ack.
  - After reset, read addr=0x30 -> prior contents (0x00000000), not 0x12345678.
